// File: rtl/axil_tcm_if.sv
// AXI4-Lite bus bundle with separate write (AW/W/B) and read (AR/R) channel modports.
interface taxi_axil_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned STRB_W = DATA_W / 8
);
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport wr_mst (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport wr_slv (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );

  modport rd_mst (
    output araddr, arprot, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport rd_slv (
    input  araddr, arprot, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_tcm.sv
// AXI4-Lite tightly-coupled data memory: byte-strobed block RAM with SLVERR outside its window.
// Define AXIL_TCM_RD_PIPE_EN to add an output register after the RAM (2-cycle read latency).
module axil_tcm #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       STRB_W    = DATA_W / 8,
  parameter int unsigned       MEM_DEPTH = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic       clk,
  input  logic       reset,
  taxi_axil_if.wr_slv s_axil_wr,
  taxi_axil_if.rd_slv s_axil_rd
);

  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned OFF_W = (STRB_W > 1) ? $clog2(STRB_W) : 0;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

  function automatic logic in_window(input logic [ADDR_W-1:0] addr);
    return (addr >= BASE_ADDR) && (((addr - BASE_ADDR) >> OFF_W) < ADDR_W'(MEM_DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_W-1:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> OFF_W);
  endfunction

  // ---------------------------------------------------------------- write path
  w_state_t          w_state, w_state_n;
  logic              aw_held, aw_held_n;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_n;
  logic              w_held, w_held_n;
  logic [DATA_W-1:0] w_data_q, w_data_n;
  logic [STRB_W-1:0] w_strb_q, w_strb_n;
  logic              awready_q, awready_n;
  logic              wready_q, wready_n;
  logic              bvalid_q, bvalid_n;
  logic [1:0]        bresp_q, bresp_n;

  logic              aw_hs, w_hs, aw_have, w_have;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;

  assign aw_hs   = s_axil_wr.awvalid && awready_q;
  assign w_hs    = s_axil_wr.wvalid && wready_q;
  assign aw_have = aw_held || aw_hs;
  assign w_have  = w_held || w_hs;
  assign wr_addr = aw_held ? aw_addr_q : s_axil_wr.awaddr;
  assign wr_data = w_held ? w_data_q : s_axil_wr.wdata;
  assign wr_strb = w_held ? w_strb_q : s_axil_wr.wstrb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state   <= W_IDLE;
      aw_held   <= 1'b0;
      aw_addr_q <= '0;
      w_held    <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state   <= w_state_n;
      aw_held   <= aw_held_n;
      aw_addr_q <= aw_addr_n;
      w_held    <= w_held_n;
      w_data_q  <= w_data_n;
      w_strb_q  <= w_strb_n;
      awready_q <= awready_n;
      wready_q  <= wready_n;
      bvalid_q  <= bvalid_n;
      bresp_q   <= bresp_n;
    end
  end

  // Commit happens on the edge where the second half arrives, so bvalid rises one cycle later.
  always_comb begin
    w_state_n = w_state;
    aw_held_n = aw_held;
    aw_addr_n = aw_addr_q;
    w_held_n  = w_held;
    w_data_n  = w_data_q;
    w_strb_n  = w_strb_q;
    bvalid_n  = bvalid_q;
    bresp_n   = bresp_q;
    mem_we    = 1'b0;
    mem_widx  = word_index(wr_addr);
    mem_wdata = wr_data;
    mem_wstrb = wr_strb;

    case (w_state)
      W_IDLE: begin
        if (aw_have && w_have) begin
          mem_we    = in_window(wr_addr);
          bresp_n   = in_window(wr_addr) ? RESP_OKAY : RESP_SLVERR;
          bvalid_n  = 1'b1;
          aw_held_n = 1'b0;
          w_held_n  = 1'b0;
          w_state_n = W_RESP;
        end else begin
          if (aw_hs) begin
            aw_held_n = 1'b1;
            aw_addr_n = s_axil_wr.awaddr;
          end
          if (w_hs) begin
            w_held_n = 1'b1;
            w_data_n = s_axil_wr.wdata;
            w_strb_n = s_axil_wr.wstrb;
          end
        end
      end
      W_RESP: begin
        if (s_axil_wr.bready) begin
          bvalid_n  = 1'b0;
          w_state_n = W_IDLE;
        end
      end
      default: w_state_n = W_IDLE;
    endcase

    awready_n = (w_state_n == W_IDLE) && !aw_held_n;
    wready_n  = (w_state_n == W_IDLE) && !w_held_n;
  end

  assign s_axil_wr.awready = awready_q;
  assign s_axil_wr.wready  = wready_q;
  assign s_axil_wr.bvalid  = bvalid_q;
  assign s_axil_wr.bresp   = bresp_q;

  // ----------------------------------------------------------------- read path
  r_state_t          r_state, r_state_n;
  logic              arready_q, arready_n;
  logic              rvalid_q, rvalid_n;
  logic [1:0]        rresp_q, rresp_n;
  logic              rd_ok_q, rd_ok_n;
  logic              ar_hs;
  logic              rd_en;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] ram_q;

  assign ar_hs  = s_axil_rd.arvalid && arready_q;
  assign rd_idx = word_index(s_axil_rd.araddr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rd_ok_q   <= 1'b0;
    end else begin
      r_state   <= r_state_n;
      arready_q <= arready_n;
      rvalid_q  <= rvalid_n;
      rresp_q   <= rresp_n;
      rd_ok_q   <= rd_ok_n;
    end
  end

  always_comb begin
    r_state_n = r_state;
    rvalid_n  = rvalid_q;
    rresp_n   = rresp_q;
    rd_ok_n   = rd_ok_q;
    rd_en     = 1'b0;

    case (r_state)
      R_IDLE: begin
        if (ar_hs) begin
          rd_en   = 1'b1;
          rd_ok_n = in_window(s_axil_rd.araddr);
`ifdef AXIL_TCM_RD_PIPE_EN
          r_state_n = R_WAIT;
`else
          rvalid_n  = 1'b1;
          rresp_n   = in_window(s_axil_rd.araddr) ? RESP_OKAY : RESP_SLVERR;
          r_state_n = R_RESP;
`endif
        end
      end
`ifdef AXIL_TCM_RD_PIPE_EN
      R_WAIT: begin
        rvalid_n  = 1'b1;
        rresp_n   = rd_ok_q ? RESP_OKAY : RESP_SLVERR;
        r_state_n = R_RESP;
      end
`endif
      R_RESP: begin
        if (s_axil_rd.rready) begin
          rvalid_n  = 1'b0;
          r_state_n = R_IDLE;
        end
      end
      default: r_state_n = R_IDLE;
    endcase

    arready_n = (r_state_n == R_IDLE);
  end

  // ----------------------------------------------------- block RAM (read-first)
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (mem_wstrb[b]) mem[mem_widx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) ram_q <= mem[rd_idx];
  end

`ifdef AXIL_TCM_RD_PIPE_EN
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (r_state == R_WAIT) begin
      rdata_q <= rd_ok_q ? ram_q : '0;
    end
  end

  assign s_axil_rd.rdata = rdata_q;
`else
  // RAM output register is not reset, so gate it to present zero outside a good response.
  assign s_axil_rd.rdata = (rvalid_q && rd_ok_q) ? ram_q : '0;
`endif

  assign s_axil_rd.arready = arready_q;
  assign s_axil_rd.rvalid  = rvalid_q;
  assign s_axil_rd.rresp   = rresp_q;

  logic unused_prot;
  assign unused_prot = ^{s_axil_wr.awprot, s_axil_rd.arprot};

endmodule

// File: tb/tb_axil_tcm.sv
// Randomized self-checking bench for axil_tcm against a word-array memory model.
module tb_axil_tcm;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned DEPTH  = 256;
  localparam logic [31:0] BASE   = 32'h0000_1000;
`ifdef AXIL_TCM_RD_PIPE_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] model [DEPTH];

  taxi_axil_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STRB_W(STRB_W)) axil ();

  axil_tcm #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STRB_W(STRB_W),
    .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s_axil_wr(axil),
    .s_axil_rd(axil)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- reference model
  function automatic bit m_in(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) / 4) < 32'(DEPTH));
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [1:0] m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (!m_in(a)) return 2'b10;
    for (int b = 0; b < 4; b++) if (s[b]) model[m_idx(a)][8*b +: 8] = d[8*b +: 8];
    return 2'b00;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [31:0] a);
    return m_in(a) ? model[m_idx(a)] : 32'h0;
  endfunction

  function automatic logic [31:0] rand_addr();
    int k;
    k = int'($urandom_range(19, 0));
    if (k < 14) return BASE + 32'($urandom_range(DEPTH*4 - 1, 0));
    else if (k < 17) return BASE + 32'(DEPTH*4) + 32'($urandom_range(15, 0));
    else return BASE - 32'($urandom_range(16, 1));
  endfunction

  // ---------------------------------------------------------------- bus drivers
  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] resp, output int lat);
    bit aw_done, w_done, b_done, a, w;
    int c, since, bw;
    aw_done = 0; w_done = 0; b_done = 0; c = 0; since = 0; bw = 0;
    lat = -1; resp = 2'b11;
    while (!b_done && c < 200) begin
      axil.awaddr  = addr;
      axil.wdata   = data;
      axil.wstrb   = strb;
      axil.awvalid = !aw_done && (c >= aw_dly);
      axil.wvalid  = !w_done && (c >= w_dly);
      axil.bready  = 1'b0;
      if (aw_done && w_done) begin
        if (axil.bvalid) begin
          if (lat < 0) lat = since;
          if (bw >= b_dly) begin
            axil.bready = 1'b1;
            resp = axil.bresp;
            b_done = 1;
          end
          bw++;
        end
        since++;
      end
      a = axil.awvalid && axil.awready;
      w = axil.wvalid && axil.wready;
      @(negedge clk);
      if (a) aw_done = 1;
      if (w) w_done = 1;
      c++;
    end
    axil.awvalid = 1'b0;
    axil.wvalid  = 1'b0;
    axil.bready  = 1'b0;
    if (!b_done) begin
      n_err++;
      $display("FAIL write_timeout: addr %h got no B response, required one within 200 cycles", addr);
    end
  endtask

  task automatic read_txn(input logic [31:0] addr, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp, output int lat);
    bit ar_done, r_done, a;
    int c, since, rw;
    ar_done = 0; r_done = 0; c = 0; since = 0; rw = 0;
    lat = -1; resp = 2'b11; data = 32'h0;
    while (!r_done && c < 200) begin
      axil.araddr  = addr;
      axil.arvalid = !ar_done;
      axil.rready  = 1'b0;
      if (ar_done) begin
        if (axil.rvalid) begin
          if (lat < 0) lat = since;
          if (rw >= r_dly) begin
            axil.rready = 1'b1;
            data = axil.rdata;
            resp = axil.rresp;
            r_done = 1;
          end
          rw++;
        end
        since++;
      end
      a = axil.arvalid && axil.arready;
      @(negedge clk);
      if (a) ar_done = 1;
      c++;
    end
    axil.arvalid = 1'b0;
    axil.rready  = 1'b0;
    if (!r_done) begin
      n_err++;
      $display("FAIL read_timeout: addr %h got no R response, required one within 200 cycles", addr);
    end
  endtask

  // ---------------------------------------------------------------- scenarios
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++; if ({axil.awready, axil.wready, axil.arready} !== 3'b000) begin n_err++;
      $display("FAIL reset_readies: got %b required 000", {axil.awready, axil.wready, axil.arready}); end
    n_vec++; if ({axil.bvalid, axil.rvalid} !== 2'b00) begin n_err++;
      $display("FAIL reset_valids: got %b required 00", {axil.bvalid, axil.rvalid}); end
    n_vec++; if ({axil.bresp, axil.rresp} !== 4'b0000 || axil.rdata !== 32'h0) begin n_err++;
      $display("FAIL reset_resp_data: got bresp %b rresp %b rdata %h required 0", axil.bresp, axil.rresp, axil.rdata); end
    reset = 1'b0;
    @(negedge clk);
    n_vec++; if ({axil.awready, axil.wready, axil.arready} !== 3'b111) begin n_err++;
      $display("FAIL reset_release_readies: got %b required 111", {axil.awready, axil.wready, axil.arready}); end
  endtask

  task automatic test_fill();
    logic [1:0] resp, er;
    logic [31:0] d;
    int lat;
    for (int i = 0; i < int'(DEPTH); i++) begin
      d = $urandom;
      write_txn(BASE + 32'(i*4), d, 4'hF, 0, 0, 0, resp, lat);
      er = m_write(BASE + 32'(i*4), d, 4'hF);
      n_vec++; if (resp !== er) begin n_err++;
        $display("FAIL fill_bresp: word %0d got %b required %b", i, resp, er); end
    end
  endtask

  task automatic test_basic();
    logic [1:0] resp, er;
    logic [31:0] d, a;
    int lat;
    a = BASE + 32'h10;
    write_txn(a, 32'hDEADBEEF, 4'hF, 0, 0, 0, resp, lat);
    er = m_write(a, 32'hDEADBEEF, 4'hF);
    n_vec++; if (resp !== er) begin n_err++; $display("FAIL basic_bresp: got %b required %b", resp, er); end
    n_vec++; if (lat != 0) begin n_err++; $display("FAIL basic_b_latency: got %0d required 0", lat); end
    read_txn(a, 0, d, resp, lat);
    n_vec++; if (d !== m_rdata(a)) begin n_err++; $display("FAIL basic_rdata: got %h required %h", d, m_rdata(a)); end
    n_vec++; if (resp !== 2'b00) begin n_err++; $display("FAIL basic_rresp: got %b required 00", resp); end
    n_vec++; if (lat != RD_LAT - 1) begin n_err++;
      $display("FAIL basic_r_latency: got %0d extra cycles required %0d", lat, RD_LAT - 1); end
  endtask

  task automatic test_strobe();
    logic [1:0] resp, er;
    logic [31:0] d, a;
    int lat;
    a = BASE + 32'h20;
    write_txn(a, 32'hFFFFFFFF, 4'hF, 0, 0, 0, resp, lat);
    void'(m_write(a, 32'hFFFFFFFF, 4'hF));
    axil.wdata = 32'h11223344; axil.wstrb = 4'b0101; axil.wvalid = 1'b1;
    @(negedge clk);
    axil.wvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_vec++; if ({axil.wready, axil.awready} !== 2'b01) begin n_err++;
        $display("FAIL strobe_w_held_readies: got wready/awready %b required 01", {axil.wready, axil.awready}); end
      @(negedge clk);
    end
    axil.awaddr = a; axil.awvalid = 1'b1;
    @(negedge clk);
    axil.awvalid = 1'b0;
    er = m_write(a, 32'h11223344, 4'b0101);
    n_vec++; if ({axil.bvalid, axil.bresp, axil.wready} !== {1'b1, er, 1'b0}) begin n_err++;
      $display("FAIL strobe_b: got bvalid %b bresp %b wready %b required 1 %b 0", axil.bvalid, axil.bresp, axil.wready, er); end
    axil.bready = 1'b1;
    @(negedge clk);
    axil.bready = 1'b0;
    n_vec++; if ({axil.bvalid, axil.wready} !== 2'b01) begin n_err++;
      $display("FAIL strobe_b_done: got bvalid/wready %b required 01", {axil.bvalid, axil.wready}); end
    read_txn(a, 0, d, resp, lat);
    n_vec++; if (d !== m_rdata(a)) begin n_err++; $display("FAIL strobe_rdata: got %h required %h", d, m_rdata(a)); end
  endtask

  task automatic test_oob();
    logic [1:0] resp, er;
    logic [31:0] d, a;
    logic [31:0] bad [2];
    int lat;
    bad[0] = BASE + 32'(DEPTH*4);
    bad[1] = BASE - 32'h4;
    for (int i = 0; i < 2; i++) begin
      a = bad[i];
      write_txn(a, 32'h5A5A5A5A, 4'hF, 0, 0, 0, resp, lat);
      er = m_write(a, 32'h5A5A5A5A, 4'hF);
      n_vec++; if (resp !== er) begin n_err++; $display("FAIL oob_bresp: addr %h got %b required %b", a, resp, er); end
      read_txn(a, 0, d, resp, lat);
      n_vec++; if (resp !== 2'b10 || d !== 32'h0) begin n_err++;
        $display("FAIL oob_read: addr %h got rresp %b rdata %h required 10 00000000", a, resp, d); end
    end
    read_txn(BASE, 0, d, resp, lat);
    n_vec++; if (d !== m_rdata(BASE)) begin n_err++; $display("FAIL oob_word0_intact: got %h required %h", d, m_rdata(BASE)); end
    a = BASE + 32'(DEPTH*4 - 4);
    read_txn(a, 0, d, resp, lat);
    n_vec++; if (d !== m_rdata(a)) begin n_err++; $display("FAIL oob_last_intact: got %h required %h", d, m_rdata(a)); end
  endtask

  task automatic test_backpressure();
    logic [1:0] er;
    logic [31:0] a, d;
    a = BASE + 32'h40;
    d = $urandom;
    axil.awaddr = a; axil.wdata = d; axil.wstrb = 4'hF;
    axil.awvalid = 1'b1; axil.wvalid = 1'b1; axil.bready = 1'b0;
    @(negedge clk);
    axil.awvalid = 1'b0; axil.wvalid = 1'b0;
    er = m_write(a, d, 4'hF);
    for (int i = 0; i < 10; i++) begin
      n_vec++; if ({axil.bvalid, axil.bresp, axil.awready, axil.wready} !== {1'b1, er, 2'b00}) begin n_err++;
        $display("FAIL bp_b_stable: cycle %0d got bvalid %b bresp %b awready %b wready %b required 1 %b 0 0",
                 i, axil.bvalid, axil.bresp, axil.awready, axil.wready, er); end
      @(negedge clk);
    end
    axil.bready = 1'b1;
    @(negedge clk);
    axil.bready = 1'b0;
    n_vec++; if ({axil.bvalid, axil.awready, axil.wready} !== 3'b011) begin n_err++;
      $display("FAIL bp_b_release: got bvalid/awready/wready %b required 011", {axil.bvalid, axil.awready, axil.wready}); end

    axil.araddr = a; axil.arvalid = 1'b1; axil.rready = 1'b0;
    @(negedge clk);
    axil.arvalid = 1'b0;
    repeat (RD_LAT - 1) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      n_vec++; if ({axil.rvalid, axil.rresp, axil.arready} !== 4'b1000 || axil.rdata !== m_rdata(a)) begin n_err++;
        $display("FAIL bp_r_stable: cycle %0d got rvalid %b rresp %b arready %b rdata %h required 1 00 0 %h",
                 i, axil.rvalid, axil.rresp, axil.arready, axil.rdata, m_rdata(a)); end
      @(negedge clk);
    end
    axil.rready = 1'b1;
    @(negedge clk);
    axil.rready = 1'b0;
    n_vec++; if ({axil.rvalid, axil.arready} !== 2'b01) begin n_err++;
      $display("FAIL bp_r_release: got rvalid/arready %b required 01", {axil.rvalid, axil.arready}); end
  endtask

  task automatic test_collision();
    logic [1:0] resp;
    logic [31:0] a, d, old;
    int lat;
    a = BASE + 32'h80;
    write_txn(a, 32'hAAAA5555, 4'hF, 0, 0, 0, resp, lat);
    void'(m_write(a, 32'hAAAA5555, 4'hF));
    n_vec++; if ({axil.awready, axil.wready, axil.arready} !== 3'b111) begin n_err++;
      $display("FAIL coll_idle_readies: got %b required 111", {axil.awready, axil.wready, axil.arready}); end
    axil.awaddr = a; axil.wdata = 32'h12345678; axil.wstrb = 4'hF; axil.araddr = a;
    axil.awvalid = 1'b1; axil.wvalid = 1'b1; axil.arvalid = 1'b1;
    axil.bready = 1'b1; axil.rready = 1'b1;
    @(negedge clk);
    axil.awvalid = 1'b0; axil.wvalid = 1'b0; axil.arvalid = 1'b0;
    old = m_rdata(a);
    void'(m_write(a, 32'h12345678, 4'hF));
    for (int i = 0; i < 10 && !axil.rvalid; i++) @(negedge clk);
    n_vec++; if (axil.rvalid !== 1'b1 || axil.rdata !== old) begin n_err++;
      $display("FAIL coll_same_cycle: got rvalid %b rdata %h required 1 %h", axil.rvalid, axil.rdata, old); end
    @(negedge clk);
    axil.bready = 1'b0; axil.rready = 1'b0;
    read_txn(a, 0, d, resp, lat);
    n_vec++; if (d !== m_rdata(a)) begin n_err++; $display("FAIL coll_next_read: got %h required %h", d, m_rdata(a)); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] resp;
    logic [31:0] a, d;
    int lat, cyc;
    time t0;
    t0 = $time;
    for (int i = 0; i < 4; i++) begin
      a = BASE + 32'(i*4 + 16'h100);
      d = $urandom;
      write_txn(a, d, 4'hF, 0, 0, 0, resp, lat);
      void'(m_write(a, d, 4'hF));
    end
    cyc = int'(($time - t0) / 10);
    n_vec++; if (cyc != 8) begin n_err++; $display("FAIL b2b_write_cycles: got %0d required 8", cyc); end
    t0 = $time;
    for (int i = 0; i < 4; i++) begin
      a = BASE + 32'(i*4 + 16'h100);
      read_txn(a, 0, d, resp, lat);
      n_vec++; if (d !== m_rdata(a)) begin n_err++; $display("FAIL b2b_rdata: addr %h got %h required %h", a, d, m_rdata(a)); end
    end
    cyc = int'(($time - t0) / 10);
    n_vec++; if (cyc != 4 * (RD_LAT + 1)) begin n_err++;
      $display("FAIL b2b_read_cycles: got %0d required %0d", cyc, 4 * (RD_LAT + 1)); end
  endtask

  task automatic test_random();
    logic [1:0] resp, er;
    logic [31:0] a, d, ed;
    logic [3:0] s;
    int lat;
    for (int n = 0; n < 300; n++) begin
      a = rand_addr();
      if ($urandom_range(1, 0) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(15, 0));
        write_txn(a, d, s, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), int'($urandom_range(2, 0)), resp, lat);
        er = m_write(a, d, s);
        n_vec++; if (resp !== er || lat != 0) begin n_err++;
          $display("FAIL rand_write: addr %h got bresp %b lat %0d required %b 0", a, resp, lat, er); end
      end else begin
        ed = m_rdata(a);
        er = m_in(a) ? 2'b00 : 2'b10;
        read_txn(a, int'($urandom_range(2, 0)), d, resp, lat);
        n_vec++; if (d !== ed || resp !== er || lat != RD_LAT - 1) begin n_err++;
          $display("FAIL rand_read: addr %h got rdata %h rresp %b lat %0d required %h %b %0d",
                   a, d, resp, lat, ed, er, RD_LAT - 1); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp, er;
    logic [31:0] a, d;
    int lat;
    axil.awaddr = BASE + 32'h10; axil.awvalid = 1'b1; axil.wvalid = 1'b0;
    axil.araddr = BASE + 32'h20; axil.arvalid = 1'b1; axil.rready = 1'b0;
    @(negedge clk);
    axil.awvalid = 1'b0; axil.arvalid = 1'b0;
    repeat (RD_LAT) @(negedge clk);
    n_vec++; if (axil.rvalid !== 1'b1 || axil.awready !== 1'b0) begin n_err++;
      $display("FAIL rmid_pending: got rvalid %b awready %b required 1 0", axil.rvalid, axil.awready); end
    #2 reset = 1'b1;
    #1;
    n_vec++; if ({axil.awready, axil.wready, axil.arready, axil.bvalid, axil.rvalid} !== 5'b00000 || axil.rdata !== 32'h0) begin n_err++;
      $display("FAIL rmid_async_clear: got aw/w/ar/b/r %b rdata %h required 00000 0",
               {axil.awready, axil.wready, axil.arready, axil.bvalid, axil.rvalid}, axil.rdata); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_vec++; if ({axil.awready, axil.wready, axil.arready} !== 3'b111) begin n_err++;
      $display("FAIL rmid_release_readies: got %b required 111", {axil.awready, axil.wready, axil.arready}); end
    // A W arriving alone must not pair with the pre-reset AW.
    a = BASE + 32'h30;
    d = $urandom;
    write_txn(a, d, 4'hF, 3, 0, 0, resp, lat);
    er = m_write(a, d, 4'hF);
    n_vec++; if (resp !== er) begin n_err++; $display("FAIL rmid_write_bresp: got %b required %b", resp, er); end
    read_txn(BASE + 32'h10, 0, d, resp, lat);
    n_vec++; if (d !== m_rdata(BASE + 32'h10)) begin n_err++;
      $display("FAIL rmid_stale_aw: got %h required %h", d, m_rdata(BASE + 32'h10)); end
    for (int i = 0; i < 8; i++) begin
      a = BASE + 32'($urandom_range(DEPTH - 1, 0) * 4);
      read_txn(a, 0, d, resp, lat);
      n_vec++; if (d !== m_rdata(a)) begin n_err++; $display("FAIL rmid_intact: addr %h got %h required %h", a, d, m_rdata(a)); end
    end
  endtask

  initial begin
    axil.awaddr = '0; axil.awprot = '0; axil.awvalid = 1'b0;
    axil.wdata = '0; axil.wstrb = '0; axil.wvalid = 1'b0; axil.bready = 1'b0;
    axil.araddr = '0; axil.arprot = '0; axil.arvalid = 1'b0; axil.rready = 1'b0;
    test_reset();
    test_fill();
    test_basic();
    test_strobe();
    test_oob();
    test_backpressure();
    test_collision();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axil_tcm.md
# axil_tcm

AXI4-Lite tightly-coupled data memory serving the core's dmem master (separate write and read channel interfaces). Sits directly downstream of the VexRiscv AXI4-Lite wrapper: it accepts AW/W/B and AR/R traffic, stores words in an inferred block RAM with byte-strobe writes, and returns SLVERR for addresses outside its window. One outstanding transaction per channel direction; no bursts.

## Interface
- DATA_W, 32, data width in bits (32 or 64)
- ADDR_W, 32, address width in bits
- STRB_W, DATA_W/8, write-strobe width
- MEM_DEPTH, 4096, memory depth in DATA_W words (power of two)
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (aligned to MEM_DEPTH*STRB_W)

- clk  input  1  sole clock; all logic rising-edge
- reset  input  1  asynchronous, active-high reset
- s_axil_wr  taxi_axil_if.wr_slv  —  AW/W/B slave (awaddr, awprot, awvalid/awready, wdata, wstrb, wvalid/wready, bresp, bvalid/bready)
- s_axil_rd  taxi_axil_if.rd_slv  —  AR/R slave (araddr, arprot, arvalid/arready, rdata, rresp, rvalid/rready)

## Operation
- Decode: offset = addr − BASE_ADDR; index = offset >> log2(STRB_W); low byte-offset bits ignored. In range iff addr ≥ BASE_ADDR and index < MEM_DEPTH. *prot ignored.
- Write path, states W_IDLE → W_RESP:
  - AW and W accepted independently into one-entry holding registers (aw_held, w_held); awready = !aw_held && state==W_IDLE, wready = !w_held && state==W_IDLE.
  - Same-cycle AW and W accepted together is legal.
  - Once both are held: in range → write bytes with wstrb bit set, bresp=OKAY (2'b00); out of range → no write, bresp=SLVERR (2'b10). Holds cleared, bvalid asserted, go to W_RESP.
  - W_RESP: bvalid/bresp stable until bvalid && bready, then W_IDLE.
  - wstrb all-zero: no bytes change, response OKAY.
- Read path, states R_IDLE → R_WAIT → R_RESP:
  - arready = state==R_IDLE. On handshake, latch range result, issue RAM read.
  - R_RESP: rvalid=1; in range → rdata=word, rresp=OKAY; out of range → rdata=0, rresp=SLVERR. rdata/rresp stable until rvalid && rready, then R_IDLE.
- Read/write collision: RAM is read-first; a write committing in the same cycle as a read of the same word returns pre-write data. A read issued the cycle after the commit returns new data.
- Reset mid-transaction: held AW/W, pending B/R discarded; memory contents untouched (never reset).

## Timing
- Reset values: awready=0, wready=0, arready=0, bvalid=0, bresp=2'b00, rvalid=0, rresp=2'b00, rdata=0. Readies assert in the first cycle after reset deasserts.
- Write: both halves held at end of cycle N → commit in N+1, bvalid high in N+1. Back-to-back AW+W with bready tied high: 1 write per 2 cycles.
- Read: AR handshake in cycle N → rvalid in N+1 (pipe off) or N+2 (pipe on). Throughput with rready high: 1 read per 2 (3) cycles.
- Readies are registered; no combinational path from any valid/ready input to any output.

## Configuration
- AXIL_TCM_RD_PIPE_EN defined: extra output register after the RAM (R_WAIT state used). AR-to-rvalid latency 2 cycles. Collision rule unchanged.
- Not defined: R_WAIT skipped. RAM output drives rdata directly, latency 1 cycle.

## Test plan
- Reset release, then AW 0x10 + W 0xDEADBEEF strb 4'hF same cycle → bvalid next cycle, bresp 2'b00; AR 0x10 → rdata 0xDEADBEEF, rresp 2'b00 after 1 cycle (2 with AXIL_TCM_RD_PIPE_EN).
- W issued 3 cycles before AW (addr 0x20, data 0x11223344, strb 4'b0101) over prior 0xFFFFFFFF → readback 0xFF22FF44; wready low after W held until B completes.
- AW to BASE_ADDR + MEM_DEPTH*4 (and to BASE_ADDR−4 when BASE_ADDR≠0) → bresp 2'b10, memory unchanged; AR same address → rresp 2'b10, rdata 0.
- bready/rready held low 10 cycles → bvalid/rvalid, bresp/rresp, rdata stable; awready/arready stay low; release → accepted next cycle.
- Read and write commit same word same cycle (old 0xAAAA5555, new 0x12345678) → read returns 0xAAAA5555; next read returns 0x12345678.
- Assert reset with AW held and R pending → all valids/readies 0 asynchronously; after release, previously written words read back intact.
